neuron_sequencer: RTL and testbench

NEURON_SEQUENCER -- requirements
Module: neuron_sequencer

---
 rtl/neuron_seq_pkg.sv | 16 +
 rtl/neuron_seq_valid_pipe.sv | 21 ++
 rtl/neuron_sequencer.sv | 167 ++++++++++++++++
 tb/tb_neuron_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_seq_pkg.sv
// Shared definitions for the neuron sequencer: state encoding and fixed datapath constants.
package neuron_seq_pkg;

    localparam int unsigned DRAIN_CYCLES = 2;
    localparam int unsigned SIGMA_W      = 5;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StIssue,
        StDrain,
        StCapture,
        StHold
    } seq_state_e;

endpackage

// File: rtl/neuron_seq_valid_pipe.sv
// Two-stage issue-valid delay line covering memory read latency plus the ALU adder register.
module neuron_seq_valid_pipe (
    input  logic clk,
    input  logic n_rst,
    input  logic issue_i,
    output logic valid_o
);

    logic [1:0] pipe_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= {pipe_q[0], issue_i};
        end
    end

    assign valid_o = pipe_q[1];

endmodule

// File: rtl/neuron_sequencer.sv
// Layer sequencer: walks groups and neurons, drives the ALU and hands off one result per neuron.
// Optional build macro NEURON_SEQ_STALL_EN adds a mem_ready input that stalls group issue.
module neuron_sequencer
    import neuron_seq_pkg::*;
#(
    parameter int unsigned GROUP_W  = 8,
    parameter int unsigned NEURON_W = 4
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                start,
    input  logic [GROUP_W-1:0]  num_groups,
    input  logic [NEURON_W-1:0] num_neurons,
`ifdef NEURON_SEQ_STALL_EN
    input  logic                mem_ready,
`endif
    output logic [GROUP_W-1:0]  group_addr,
    output logic [NEURON_W-1:0] neuron_idx,
    output logic                alu_clear,
    output logic                alu_accumulate,
    input  logic [SIGMA_W-1:0]  alu_sigma,
    output logic [SIGMA_W-1:0]  result,
    output logic                result_valid,
    input  logic                result_ack,
    output logic                busy,
    output logic                done,
    output logic                cfg_err
);

    localparam int unsigned DrainW = $clog2(DRAIN_CYCLES);

    seq_state_e          state_q, state_d;
    logic [GROUP_W-1:0]  groups_q, groups_d;
    logic [NEURON_W-1:0] neurons_q, neurons_d;
    logic [GROUP_W-1:0]  addr_q, addr_d;
    logic [NEURON_W-1:0] idx_q, idx_d;
    logic [SIGMA_W-1:0]  result_q, result_d;
    logic                valid_q, valid_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [DrainW-1:0]   drain_q, drain_d;
    logic                issue;
    logic                mem_rdy;

`ifdef NEURON_SEQ_STALL_EN
    assign mem_rdy = mem_ready;
`else
    assign mem_rdy = 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        groups_d  = groups_q;
        neurons_d = neurons_q;
        addr_d    = addr_q;
        idx_d     = idx_q;
        result_d  = result_q;
        valid_d   = valid_q;
        drain_d   = drain_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        issue     = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    if ((num_groups != '0) && (num_neurons != '0)) begin
                        groups_d  = num_groups;
                        neurons_d = num_neurons;
                        idx_d     = '0;
                        addr_d    = '0;
                        state_d   = StClear;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StClear: begin
                addr_d  = '0;
                state_d = StIssue;
            end
            StIssue: begin
                if (mem_rdy) begin
                    issue = 1'b1;
                    // Hold the address on the last group so it never overflows past the count.
                    if (addr_q == groups_q - GROUP_W'(1)) begin
                        drain_d = '0;
                        state_d = StDrain;
                    end else begin
                        addr_d = addr_q + GROUP_W'(1);
                    end
                end
            end
            StDrain: begin
                if (drain_q == DrainW'(DRAIN_CYCLES - 1)) begin
                    state_d = StCapture;
                end else begin
                    drain_d = drain_q + DrainW'(1);
                end
            end
            StCapture: begin
                result_d = alu_sigma;
                valid_d  = 1'b1;
                state_d  = StHold;
            end
            StHold: begin
                if (result_ack && valid_q) begin
                    valid_d = 1'b0;
                    if (idx_q == neurons_q - NEURON_W'(1)) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        idx_d   = idx_q + NEURON_W'(1);
                        addr_d  = '0;
                        state_d = StClear;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= StIdle;
            groups_q  <= '0;
            neurons_q <= '0;
            addr_q    <= '0;
            idx_q     <= '0;
            result_q  <= '0;
            valid_q   <= 1'b0;
            drain_q   <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            groups_q  <= groups_d;
            neurons_q <= neurons_d;
            addr_q    <= addr_d;
            idx_q     <= idx_d;
            result_q  <= result_d;
            valid_q   <= valid_d;
            drain_q   <= drain_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    neuron_seq_valid_pipe u_valid_pipe (
        .clk     (clk),
        .n_rst   (n_rst),
        .issue_i (issue),
        .valid_o (alu_accumulate)
    );

    assign group_addr   = addr_q;
    assign neuron_idx   = idx_q;
    assign alu_clear    = (state_q == StClear);
    assign busy         = (state_q != StIdle);
    assign result       = result_q;
    assign result_valid = valid_q;
    assign done         = done_q;
    assign cfg_err      = err_q;

endmodule

// File: tb/tb_neuron_sequencer.sv
// Self-checking bench for neuron_sequencer: behavioural ALU, result scoreboard, vector table.
module tb_neuron_sequencer;

    localparam int GW = 8;
    localparam int NW = 4;

    logic          clk = 1'b0;
    logic          n_rst;
    logic          start;
    logic [GW-1:0] num_groups;
    logic [NW-1:0] num_neurons;
    logic [GW-1:0] group_addr;
    logic [NW-1:0] neuron_idx;
    logic          alu_clear;
    logic          alu_accumulate;
    logic [4:0]    alu_sigma;
    logic [4:0]    result;
    logic          result_valid;
    logic          result_ack;
    logic          busy;
    logic          done;
    logic          cfg_err;
`ifdef NEURON_SEQ_STALL_EN
    logic          mem_ready;
`endif

    always #5 clk = ~clk;

    neuron_sequencer #(
        .GROUP_W  (GW),
        .NEURON_W (NW)
    ) dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .start          (start),
        .num_groups     (num_groups),
        .num_neurons    (num_neurons),
`ifdef NEURON_SEQ_STALL_EN
        .mem_ready      (mem_ready),
`endif
        .group_addr     (group_addr),
        .neuron_idx     (neuron_idx),
        .alu_clear      (alu_clear),
        .alu_accumulate (alu_accumulate),
        .alu_sigma      (alu_sigma),
        .result         (result),
        .result_valid   (result_valid),
        .result_ack     (result_ack),
        .busy           (busy),
        .done           (done),
        .cfg_err        (cfg_err)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ALU model: accumulate (address + 1) of the group issued two cycles earlier.
    logic [31:0]   acc;
    logic [GW-1:0] p1, p2;
    logic [31:0]   sig_full;
    assign sig_full  = acc + 32'(neuron_idx) * 32'd3;
    assign alu_sigma = sig_full[4:0];

    always @(negedge clk) begin
        if (alu_clear) acc <= '0;
        else if (alu_accumulate) acc <= acc + 32'(p2) + 32'd1;
        p2 <= p1;
        p1 <= group_addr;
    end

    typedef struct {
        logic [4:0]    res;
        logic [NW-1:0] idx;
        int            groups;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   acc_cnt;
    logic rv_prev;

    always @(negedge clk) begin
        if (!n_rst) begin
            rv_prev <= 1'b0;
            acc_cnt <= 0;
        end else begin
            rv_prev <= result_valid;
            if (alu_clear) acc_cnt <= 0;
            else if (alu_accumulate) acc_cnt <= acc_cnt + 1;
            if (result_valid && !rv_prev) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 64'(exp_q.size()), 64'd1);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("result", 64'(result), 64'(mon_e.res));
                    check("neuron_idx", 64'(neuron_idx), 64'(mon_e.idx));
                    check("accum_pulses", 64'(acc_cnt), 64'(mon_e.groups));
                end
            end
        end
    end

    task automatic push_layer(input int ng, input int nn);
        exp_t e;
        for (int i = 0; i < nn; i++) begin
            e.res    = 5'((ng * (ng + 1)) / 2 + 3 * i);
            e.idx    = NW'(i);
            e.groups = ng;
            exp_q.push_back(e);
        end
    endtask

    // Returns at the negedge following the edge that samples start.
    task automatic pulse_start(input int ng, input int nn);
        @(negedge clk);
        start       = 1'b1;
        num_groups  = GW'(ng);
        num_neurons = NW'(nn);
        @(negedge clk);
        start       = 1'b0;
        num_groups  = ~num_groups;
        num_neurons = ~num_neurons;
    endtask

    task automatic wait_valid(input int ng, input int cnt0, input string tag);
        int cnt = cnt0;
        while (!result_valid && cnt < ng + 40) begin
            @(negedge clk);
            cnt++;
        end
        check({tag, "_latency"}, 64'(cnt), 64'(ng + 4));
    endtask

    task automatic run_layer(input int ng, input int nn, input int ack_delay, input bit spurious);
        int   cnt0;
        bit   stable;
        logic [4:0] held;
        push_layer(ng, nn);
        pulse_start(ng, nn);
        check("clear_after_start", 64'(alu_clear), 64'd1);
        check("busy_after_start", 64'(busy), 64'd1);
        cnt0 = 0;
        if (spurious) begin
            start       = 1'b1;
            num_groups  = 8'd9;
            num_neurons = 4'd1;
            result_ack  = 1'b1;
            @(negedge clk);
            start      = 1'b0;
            result_ack = 1'b0;
            cnt0       = 1;
        end
        for (int i = 0; i < nn; i++) begin
            wait_valid(ng, cnt0, "valid");
            if (ack_delay > 0) begin
                stable = 1'b1;
                held   = result;
                for (int k = 0; k < ack_delay; k++) begin
                    start = spurious && (k == 10);
                    @(negedge clk);
                    stable &= (result == held) && result_valid && !alu_accumulate && !alu_clear;
                end
                start = 1'b0;
                check("hold_stable", 64'(stable), 64'd1);
            end
            result_ack = 1'b1;
            @(negedge clk);
            result_ack = 1'b0;
            cnt0       = 0;
        end
        check("done_pulse", 64'(done), 64'd1);
        check("busy_after_done", 64'(busy), 64'd0);
        check("valid_after_done", 64'(result_valid), 64'd0);
        @(negedge clk);
        check("done_single", 64'(done), 64'd0);
    endtask

    task automatic run_bad(input int ng, input int nn);
        pulse_start(ng, nn);
        check("cfg_err_pulse", 64'(cfg_err), 64'd1);
        check("cfg_err_busy", 64'(busy), 64'd0);
        check("cfg_err_clear", 64'(alu_clear), 64'd0);
        @(negedge clk);
        check("cfg_err_single", 64'(cfg_err), 64'd0);
        check("cfg_err_idle", 64'(busy), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_group_addr"}, 64'(group_addr), 64'd0);
        check({tag, "_neuron_idx"}, 64'(neuron_idx), 64'd0);
        check({tag, "_result"}, 64'(result), 64'd0);
        check({tag, "_result_valid"}, 64'(result_valid), 64'd0);
        check({tag, "_alu_clear"}, 64'(alu_clear), 64'd0);
        check({tag, "_alu_accumulate"}, 64'(alu_accumulate), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_cfg_err"}, 64'(cfg_err), 64'd0);
    endtask

    typedef struct {
        int ng;
        int nn;
        int ack_delay;
        bit bad;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{ng: 1,   nn: 1,  ack_delay: 0, bad: 1'b0};
        vecs[1] = '{ng: 3,   nn: 2,  ack_delay: 0, bad: 1'b0};
        vecs[2] = '{ng: 196, nn: 10, ack_delay: 0, bad: 1'b0};
        vecs[3] = '{ng: 0,   nn: 3,  ack_delay: 0, bad: 1'b1};
        vecs[4] = '{ng: 5,   nn: 0,  ack_delay: 0, bad: 1'b1};
        vecs[5] = '{ng: 255, nn: 1,  ack_delay: 1, bad: 1'b0};
        vecs[6] = '{ng: 2,   nn: 3,  ack_delay: 2, bad: 1'b0};
        vecs[7] = '{ng: 7,   nn: 15, ack_delay: 0, bad: 1'b0};

        n_rst       = 1'b0;
        start       = 1'b0;
        num_groups  = '0;
        num_neurons = '0;
        result_ack  = 1'b0;
`ifdef NEURON_SEQ_STALL_EN
        mem_ready   = 1'b1;
`endif
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        n_rst = 1'b1;
        @(negedge clk);

        foreach (vecs[v]) begin
            if (vecs[v].bad) run_bad(vecs[v].ng, vecs[v].nn);
            else run_layer(vecs[v].ng, vecs[v].nn, vecs[v].ack_delay, 1'b0);
        end

        // Long hold with ignored start/ack pulses while busy.
        run_layer(3, 2, 20, 1'b1);

        // Asynchronous reset in the middle of ISSUE.
        begin
            bit quiet;
            pulse_start(50, 2);
            repeat (8) @(negedge clk);
            #2 n_rst = 1'b0;
            #1 check_reset_outputs("midrst");
            quiet = 1'b1;
            repeat (2) begin
                @(negedge clk);
                quiet &= !alu_accumulate && !busy;
            end
            n_rst = 1'b1;
            repeat (4) begin
                @(negedge clk);
                quiet &= !alu_accumulate && !busy && !alu_clear;
            end
            check("midrst_quiet", 64'(quiet), 64'd1);
            run_layer(6, 2, 0, 1'b0);
        end

`ifdef NEURON_SEQ_STALL_EN
        begin
            logic [6:0] pat;
            bit         acc_exp;
            pat = 7'b1011001;  // bit k-1 is mem_ready in issue cycle k: 1,0,0,1,1,0,1
            push_layer(4, 1);
            pulse_start(4, 1);
            for (int k = 0; k <= 11; k++) begin
                acc_exp = (k == 3) || (k == 6) || (k == 7) || (k == 9);
                check("stall_accum", 64'(alu_accumulate), 64'(acc_exp));
                if (k == 10) check("stall_valid_early", 64'(result_valid), 64'd0);
                if (k >= 1 && k <= 7) mem_ready = pat[k-1];
                else mem_ready = 1'b1;
                if (k < 11) @(negedge clk);
            end
            check("stall_valid", 64'(result_valid), 64'd1);
            result_ack = 1'b1;
            @(negedge clk);
            result_ack = 1'b0;
            check("stall_done", 64'(done), 64'd1);
        end
`endif

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
